// File: rtl/dht11_reader.sv
// DHT11 single-wire master: start pulse, response handshake, 40-bit capture
// with pulse-width decoding, and checksum verification.
module dht11_reader #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int START_LOW_US  = 18000,
  parameter int BIT_THRESH_US = 40,
  parameter int TIMEOUT_US    = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  inout  wire         dado,
  output logic [39:0] data_out,
  output logic        busy,
  output logic        error,
  output logic        done
);

  localparam int CYC_US = (CLK_FREQ_HZ / 1_000_000 < 1) ? 1 : CLK_FREQ_HZ / 1_000_000;
  localparam int TW     = $clog2(CYC_US + 1);
  localparam int DW     = $clog2(START_LOW_US + TIMEOUT_US + 2);

  typedef enum logic [3:0] {
    IDLE, START, WAIT_RESP, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, CHECK, ERR, DONE
  } state_t;

  state_t          state, state_nx;
  logic [1:0]      sync;
  logic            prev, rise, fall;
  logic [TW-1:0]   tick_cnt;
  logic            tick, timeout, bit_one;
  logic [DW-1:0]   dur;
  logic [39:0]     sr;
  logic [5:0]      nbit;
  logic [7:0]      sum;

  // Open-drain: only ever pull low, and only during the start pulse.
  assign dado = (state == START) ? 1'b0 : 1'bz;
  assign busy = !(state == IDLE || state == DONE);

  assign rise    = sync[1] & ~prev;
  assign fall    = ~sync[1] & prev;
  assign tick    = (tick_cnt == TW'(CYC_US - 1));
  assign timeout = (dur >= DW'(TIMEOUT_US));
  // dur counts completed us before the current one, so +1 gives the width.
  assign bit_one = (({1'b0, dur} + 1'b1) >= (DW + 1)'(BIT_THRESH_US));
  assign sum     = sr[39:32] + sr[31:24] + sr[23:16] + sr[15:8];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (enable) state_nx = START;
      START:     if (tick && dur == DW'(START_LOW_US - 1)) state_nx = WAIT_RESP;
      WAIT_RESP: if (fall) state_nx = RESP_LOW;  else if (timeout) state_nx = ERR;
      RESP_LOW:  if (rise) state_nx = RESP_HIGH; else if (timeout) state_nx = ERR;
      RESP_HIGH: if (fall) state_nx = BIT_LOW;   else if (timeout) state_nx = ERR;
      BIT_LOW:   if (rise) state_nx = BIT_HIGH;  else if (timeout) state_nx = ERR;
      BIT_HIGH:  if (fall) state_nx = (nbit == 6'd39) ? CHECK : BIT_LOW;
                 else if (timeout) state_nx = ERR;
      CHECK:     state_nx = DONE;
      ERR:       state_nx = DONE;
      DONE:      if (!enable) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      sync     <= 2'b11;
      prev     <= 1'b1;
      tick_cnt <= '0;
      dur      <= '0;
      sr       <= '0;
      nbit     <= '0;
      data_out <= '0;
      error    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nx;
      sync  <= {sync[0], dado};
      prev  <= sync[1];

      // Both timers restart on every state change.
      if (state_nx != state) begin
        tick_cnt <= '0;
        dur      <= '0;
      end else if (busy) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) dur <= dur + 1'b1;
      end

      if (state == RESP_HIGH && fall) nbit <= '0;
      if (state == BIT_HIGH && fall) begin
        sr   <= {sr[38:0], bit_one};
        nbit <= nbit + 1'b1;
      end

      case (state)
        IDLE:  if (enable) begin
                 error <= 1'b0;
                 done  <= 1'b0;
               end
        CHECK: begin
                 data_out <= sr;
                 error    <= (sum != sr[7:0]);
                 done     <= 1'b1;
               end
        ERR:   begin
                 error <= 1'b1;
                 done  <= 1'b1;
               end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_reader.sv
// Bench for dht11_reader at 1 cycle/us with a behavioural DHT11 on the line;
// expected frames come from decoding the pulse widths the sensor emits.
module tb_dht11_reader;
  localparam int START_US = 18000;
  localparam int THR      = 40;
  localparam int TO       = 200;

  logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, sensor_low = 1'b0;
  wire         dado;
  logic [39:0] data_out;
  logic        busy, error, done;

  int n_chk = 0, n_pass = 0;
  int w[40];

  pullup (dado);
  assign dado = sensor_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  dht11_reader #(
    .CLK_FREQ_HZ(1_000_000), .START_LOW_US(START_US),
    .BIT_THRESH_US(THR), .TIMEOUT_US(TO)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .dado(dado),
    .data_out(data_out), .busy(busy), .error(error), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic hold(input int n, input logic low);
    sensor_low = low;
    repeat (n) @(negedge clk);
  endtask

  // Reference: a high pulse of THR us or more is a 1, sent MSB first.
  function automatic logic [39:0] decode();
    logic [39:0] f = '0;
    for (int i = 0; i < 40; i++) f = {f[38:0], (w[i] >= THR)};
    return f;
  endfunction

  function automatic logic cks_bad(input logic [39:0] f);
    int s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return (s % 256) != int'(f[7:0]);
  endfunction

  task automatic set_widths(input logic [39:0] f, input bit rnd);
    bit z = 0, o = 0;
    for (int i = 0; i < 40; i++) begin
      if (!rnd) w[i] = f[39-i] ? 70 : 26;
      else      w[i] = f[39-i] ? int'($urandom_range(75, 40)) : int'($urandom_range(39, 20));
      if (rnd && !f[39-i] && !z) begin w[i] = 39; z = 1; end
      else if (rnd && f[39-i] && !o) begin w[i] = 40; o = 1; end
    end
  endtask

  task automatic start_read(output int low_cnt);
    int t = 0;
    enable = 1'b1;
    @(negedge clk);
    while (dado !== 1'b0 && t < 5) begin t++; @(negedge clk); end
    chk("start_drive", dado, 0);
    chk("start_clr_done", done, 0);
    chk("start_clr_error", error, 0);
    chk("start_busy", busy, 1);
    low_cnt = 0;
    while (dado === 1'b0 && low_cnt < 20000) begin low_cnt++; @(negedge clk); end
  endtask

  task automatic play(input int nbits);
    hold($urandom_range(40, 20), 1'b0);
    hold(80, 1'b1);
    hold(80, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      hold(50, 1'b1);
      hold(w[i], 1'b0);
    end
    if (nbits == 40) hold(50, 1'b1);
    sensor_low = 1'b0;
  endtask

  task automatic wait_done(output int t);
    t = 0;
    while (done !== 1'b1 && t < 400) begin t++; @(negedge clk); end
    chk("done_in_time", done, 1);
  endtask

  initial begin
    int lc, t, nlow;
    logic [39:0] exp_f;
    logic [7:0]  b[4];

    repeat (3) @(negedge clk);
    chk("rst_data", data_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_done", done, 0);
    chk("rst_line", dado, 1);
    reset = 1'b1;
    @(negedge clk);

    // Normal read with nominal 26/70 us pulses.
    set_widths(40'h3700190050, 0);
    exp_f = decode();
    start_read(lc);
    chk("r1_start_low", (lc >= START_US && lc <= START_US + 2), 1);
    play(40);
    wait_done(t);
    chk("r1_data", data_out, exp_f);
    chk("r1_error", error, cks_bad(exp_f));
    chk("r1_busy", busy, 0);

    // enable held high after done: no new start pulse.
    nlow = 0;
    repeat (300) begin @(negedge clk); if (dado === 1'b0) nlow++; end
    chk("hold_no_restart", nlow, 0);
    chk("hold_done", done, 1);
    enable = 1'b0;
    @(negedge clk);
    chk("idle_done_kept", done, 1);
    chk("idle_busy", busy, 0);

    // Bad checksum with randomised widths, including 39 and 40 us pulses.
    set_widths(40'h3700190051, 1);
    exp_f = decode();
    start_read(lc);
    play(40);
    wait_done(t);
    chk("r2_data", data_out, exp_f);
    chk("r2_error", error, cks_bad(exp_f));
    chk("r2_done", done, 1);

    // No sensor: timeout after the start pulse, previous frame kept.
    enable = 1'b0;
    @(negedge clk);
    start_read(lc);
    wait_done(t);
    chk("r3_timeout_window", (lc + t >= START_US + TO && lc + t <= START_US + TO + 10), 1);
    chk("r3_data_kept", data_out, exp_f);
    chk("r3_error", error, 1);

    // Reset while a random frame is mid-bit.
    enable = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    set_widths({b[0], b[1], b[2], b[3], 8'(b[0] + b[1] + b[2] + b[3])}, 1);
    start_read(lc);
    play(20);
    chk("r4_busy_mid", busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("r4_rst_data", data_out, 0);
    chk("r4_rst_busy", busy, 0);
    chk("r4_rst_error", error, 0);
    chk("r4_rst_done", done, 0);
    chk("r4_rst_line", dado, 1);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("r4_idle_line", dado, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
